load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- CPU-side initiator for the 4 KiB simple-dual-port data SRAM. It turns byte-addressed RV32 load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into SRAM port-A writes and port-B reads.
- The SRAM has no byte enables, so sub-word stores run as read-modify-write.
- Loads are extracted from the returned word and sign- or zero-extended.
- Sits between the execute stage and the data SRAM.

Parameters:
- ARCH, 32, data width. Only 32 is supported.
- RAM_DEPTH, 4096, SRAM depth. Sets ADDR_W = $clog2(RAM_DEPTH) = 12.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_in  in  1  request valid
- req_ready_out  out  1  unit can accept a request
- req_we_in  in  1  1 = store, 0 = load
- req_size_in  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_in  in  1  zero-extend load (LBU/LHU)
- req_addr_in  in  ADDR_W  byte address
- req_wdata_in  in  ARCH  store data; the value sits in the low bits
- resp_valid_out  out  1  one-cycle response pulse
- resp_rdata_out  out  ARCH  extended load data; 0 for stores and errors
- resp_err_out  out  1  misaligned or illegal-size request
- mem_addr_a_out  out  ADDR_W  SRAM write byte address
- mem_din_a_out  out  ARCH  SRAM write data
- mem_we_a_out  out  1  SRAM write enable
- mem_addr_b_out  out  ADDR_W  SRAM read byte address
- mem_en_b_out  out  1  SRAM read enable
- mem_dout_b_in  in  ARCH  SRAM read data, valid the cycle after mem_en_b_out

Behaviour:
- Reset:
  - state=IDLE.
  - resp_valid_out=0, resp_rdata_out=0, resp_err_out=0.
  - Captured request registers are cleared.
  - mem_we_a_out and mem_en_b_out are forced to 0 in any cycle where rst=1, whatever the state.
  - Reset during LOAD_WAIT or STORE_MERGE abandons the operation: no write is issued and no response is given.
- States: IDLE, LOAD_WAIT, STORE_MERGE.
- Handshake:
  - req_ready_out = (state==IDLE) and not rst.
  - A request is accepted when req_valid_in && req_ready_out.
  - On accept, addr, size, unsigned flag and wdata are captured.
- Alignment check on accept:
  - Error if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]!=0.
  - On error: no SRAM access; next cycle resp_valid_out=1, resp_err_out=1, resp_rdata_out=0; stay IDLE.
- Word store:
  - In the accept cycle, combinationally drive mem_we_a_out=1, mem_addr_a_out=req_addr_in, mem_din_a_out=req_wdata_in.
  - Next cycle: resp_valid_out=1. Stay IDLE.
  - Latency 1.
- Load:
  - In the accept cycle, mem_en_b_out=1 and mem_addr_b_out=req_addr_in. Go to LOAD_WAIT.
  - In LOAD_WAIT: lane = addr[1:0]; shift mem_dout_b_in right by lane*8.
  - Take 8 or 16 bits, or all 32 for a word.
  - Sign-extend unless the unsigned flag is set; the flag is ignored for word loads.
  - Register the result into resp_rdata_out. Go to IDLE.
  - resp_valid_out=1 the following cycle. Latency 2.
- Sub-word store:
  - In the accept cycle, issue a port-B read of the addressed word. Go to STORE_MERGE.
  - In STORE_MERGE: mem_we_a_out=1 and mem_addr_a_out = captured address.
  - mem_din_a_out = mem_dout_b_in with the addressed lane(s) replaced by wdata[7:0] (byte) or wdata[15:0] (half at lane addr[1]*2).
  - Go to IDLE; resp_valid_out=1 the next cycle. Latency 2.
- Response timing:
  - resp_valid_out is high for exactly one cycle per accepted request.
  - That cycle coincides with state=IDLE, so req_ready_out=1 and a new request may be accepted in the same cycle.
- Back-to-back ordering:
  - A write committed at clock edge N is visible to a read issued in the cycle after edge N.
  - No forwarding logic is required.
- Outside active cycles, mem_* address and data outputs are don't-care but must be deterministic; drive them from the captured registers.

Test Plan:
- SW addr 0x010, data 0x8899AABB: accept cycle shows mem_we_a=1, addr_a=0x010, din=0x8899AABB; resp_valid one cycle later with err=0. Then LW 0x010: resp_rdata=0x8899AABB exactly 2 cycles after accept.
- Sub-word loads against that word:
  - LB 0x011 → 0xFFFFFFAA; LBU 0x011 → 0x000000AA.
  - LH 0x012 → 0xFFFF8899; LHU 0x012 → 0x00008899.
  - LB 0x010 → 0xFFFFFFBB.
- SB 0x013, data 0x12345677: accept cycle shows en_b=1; the next cycle shows we_a=1 with din=0x7799AABB; resp 2 cycles after accept. A following LW 0x010 returns 0x7799AABB.
- Illegal requests (SH 0x011, LW 0x012, size=11): resp_valid with err=1 and rdata=0 one cycle after accept; mem_we_a and mem_en_b never asserted.
- SH 0x010, data 0xCAFE, with rst asserted during the STORE_MERGE cycle: mem_we_a stays 0; all outputs are 0 after reset; LW 0x010 still returns the prior value; req_ready=1 the first cycle after rst deasserts.
- SW 0x020 = 0x11223344, then LW 0x020 accepted in the very next cycle: returns 0x11223344. Also, SB issued in the same cycle as a previous resp_valid is accepted with no bubble.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit_if
// Purpose : Request/response and data-SRAM bus bundle for the load/store unit.
// Revision: 1.0
// ============================================================================
interface load_store_unit_if #(
   parameter int ARCH   = 32,
   parameter int ADDR_W = 12
);
   logic              req_valid_in;
   logic              req_ready_out;
   logic              req_we_in;
   logic [1:0]        req_size_in;
   logic              req_unsigned_in;
   logic [ADDR_W-1:0] req_addr_in;
   logic [ARCH-1:0]   req_wdata_in;
   logic              resp_valid_out;
   logic [ARCH-1:0]   resp_rdata_out;
   logic              resp_err_out;
   logic [ADDR_W-1:0] mem_addr_a_out;
   logic [ARCH-1:0]   mem_din_a_out;
   logic              mem_we_a_out;
   logic [ADDR_W-1:0] mem_addr_b_out;
   logic              mem_en_b_out;
   logic [ARCH-1:0]   mem_dout_b_in;

   // Master is the execute stage plus the SRAM read-data return path.
   modport master (
      output req_valid_in, req_we_in, req_size_in, req_unsigned_in,
             req_addr_in, req_wdata_in, mem_dout_b_in,
      input  req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
             mem_addr_a_out, mem_din_a_out, mem_we_a_out,
             mem_addr_b_out, mem_en_b_out
   );

   modport slave (
      input  req_valid_in, req_we_in, req_size_in, req_unsigned_in,
             req_addr_in, req_wdata_in, mem_dout_b_in,
      output req_ready_out, resp_valid_out, resp_rdata_out, resp_err_out,
             mem_addr_a_out, mem_din_a_out, mem_we_a_out,
             mem_addr_b_out, mem_en_b_out
   );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : load_store_unit
// Purpose : RV32 load/store initiator for a byte-enable-less dual-port SRAM.
// Revision: 1.0
// ============================================================================
module load_store_unit #(
   parameter int ARCH      = 32,
   parameter int RAM_DEPTH = 4096
) (
   input  wire logic           clk,
   input  wire logic           rst,
   load_store_unit_if.slave    bus
);
   localparam int ADDR_W = $clog2(RAM_DEPTH);

   localparam logic [1:0] c_SIZE_BYTE = 2'b00;
   localparam logic [1:0] c_SIZE_HALF = 2'b01;
   localparam logic [1:0] c_SIZE_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      LOAD_WAIT   = 2'd1,
      STORE_MERGE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_addr;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic [ARCH-1:0]   r_wdata;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic [ARCH-1:0]   r_resp_rdata;

   logic              w_ready;
   logic              w_accept;
   logic              w_illegal;
   logic              w_word_store;
   logic [ARCH-1:0]   w_shifted;
   logic [ARCH-1:0]   w_load_data;
   logic [ARCH-1:0]   w_merged;
   logic              w_we_a;
   logic [ADDR_W-1:0] w_addr_a;
   logic [ARCH-1:0]   w_din_a;
   logic              w_en_b;
   logic [ADDR_W-1:0] w_addr_b;

   assign w_ready      = (r_state == IDLE) && !rst;
   assign w_accept     = bus.req_valid_in && w_ready;
   assign w_word_store = bus.req_we_in && (bus.req_size_in == c_SIZE_WORD);

   always_comb begin
      w_illegal = 1'b0;
      case (bus.req_size_in)
         c_SIZE_BYTE: w_illegal = 1'b0;
         c_SIZE_HALF: w_illegal = bus.req_addr_in[0];
         c_SIZE_WORD: w_illegal = (bus.req_addr_in[1:0] != 2'b00);
         default:     w_illegal = 1'b1;
      endcase
   end

   // Returned word is aligned to the addressed lane before extension.
   assign w_shifted = bus.mem_dout_b_in >> {r_addr[1:0], 3'b000};

   always_comb begin
      w_load_data = w_shifted;
      case (r_size)
         c_SIZE_BYTE: w_load_data = r_unsigned ? {{(ARCH-8){1'b0}}, w_shifted[7:0]}
                                               : {{(ARCH-8){w_shifted[7]}}, w_shifted[7:0]};
         c_SIZE_HALF: w_load_data = r_unsigned ? {{(ARCH-16){1'b0}}, w_shifted[15:0]}
                                               : {{(ARCH-16){w_shifted[15]}}, w_shifted[15:0]};
         default:     w_load_data = w_shifted;
      endcase
   end

   always_comb begin
      w_merged = bus.mem_dout_b_in;
      if (r_size == c_SIZE_BYTE)
         w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      else
         w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
   end

   always_comb begin
      w_state_next = r_state;
      w_we_a       = 1'b0;
      w_addr_a     = r_addr;
      w_din_a      = r_wdata;
      w_en_b       = 1'b0;
      w_addr_b     = r_addr;
      case (r_state)
         IDLE: begin
            if (w_accept && !w_illegal) begin
               if (w_word_store) begin
                  w_we_a   = 1'b1;
                  w_addr_a = bus.req_addr_in;
                  w_din_a  = bus.req_wdata_in;
               end else begin
                  w_en_b       = 1'b1;
                  w_addr_b     = bus.req_addr_in;
                  w_state_next = bus.req_we_in ? STORE_MERGE : LOAD_WAIT;
               end
            end
         end
         LOAD_WAIT: w_state_next = IDLE;
         STORE_MERGE: begin
            w_we_a       = 1'b1;
            w_din_a      = w_merged;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
      // Reset must never let a pending merge reach the array.
      if (rst) begin
         w_we_a = 1'b0;
         w_en_b = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_size       <= 2'b00;
         r_unsigned   <= 1'b0;
         r_wdata      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_addr     <= bus.req_addr_in;
            r_size     <= bus.req_size_in;
            r_unsigned <= bus.req_unsigned_in;
            r_wdata    <= bus.req_wdata_in;
         end
         r_resp_valid <= (w_accept && (w_illegal || w_word_store)) || (r_state != IDLE);
         r_resp_err   <= w_accept && w_illegal;
         r_resp_rdata <= (r_state == LOAD_WAIT) ? w_load_data : '0;
      end
   end

   assign bus.req_ready_out  = w_ready;
   assign bus.resp_valid_out = r_resp_valid;
   assign bus.resp_err_out   = r_resp_err;
   assign bus.resp_rdata_out = r_resp_rdata;
   assign bus.mem_we_a_out   = w_we_a;
   assign bus.mem_addr_a_out = w_addr_a;
   assign bus.mem_din_a_out  = w_din_a;
   assign bus.mem_en_b_out   = w_en_b;
   assign bus.mem_addr_b_out = w_addr_b;
endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_load_store_unit
// Purpose : Directed bench with a word-array memory model and response queues.
// Revision: 1.0
// ============================================================================
module tb_load_store_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   load_store_unit_if #(.ARCH(32), .ADDR_W(12)) bus ();

   load_store_unit #(.ARCH(32), .RAM_DEPTH(4096)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // SRAM: one-cycle read latency, word-granular.
   logic [31:0] sram [0:1023];
   initial for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
   always @(posedge clk) begin
      if (bus.mem_we_a_out === 1'b1) sram[bus.mem_addr_a_out[11:2]] <= bus.mem_din_a_out;
      if (bus.mem_en_b_out === 1'b1) bus.mem_dout_b_in <= sram[bus.mem_addr_b_out[11:2]];
   end

   typedef struct {
      int          due;
      logic        err;
      logic [31:0] data;
      logic        use_lit;
      logic [31:0] lit;
   } resp_t;
   typedef struct {
      int          due;
      logic [11:0] addr;
      logic [31:0] data;
      logic        use_lit;
      logic [31:0] lit;
   } wr_t;

   resp_t       rq[$];
   wr_t         wq[$];
   logic [31:0] ref_mem [0:1023];
   initial for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [31:0] model_load(input logic [11:0] addr, input logic [1:0] size,
                                              input logic uns);
      int unsigned w = ref_mem[addr / 4];
      int v;
      if (size == 2'd0) begin
         v = int'((w >> (8 * (addr % 4))) & 32'hFF);
         if (!uns && v >= 128) v = v - 256;
      end else if (size == 2'd1) begin
         v = int'((w >> (16 * ((addr % 4) / 2))) & 32'hFFFF);
         if (!uns && v >= 32768) v = v - 65536;
      end else begin
         v = int'(w);
      end
      return 32'(v);
   endfunction

   function automatic logic [31:0] model_store(input logic [11:0] addr, input logic [1:0] size,
                                               input logic [31:0] wdata);
      logic [31:0] w = ref_mem[addr / 4];
      logic [31:0] mask;
      int          sh;
      if (size == 2'd2) return wdata;
      sh   = (size == 2'd0) ? 8 * (addr % 4) : 16 * ((addr % 4) / 2);
      mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
      return (w & ~mask) | ((wdata << sh) & mask);
   endfunction

   task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                        input logic [11:0] addr, input logic [31:0] wdata, input logic model,
                        input logic use_lit, input logic [31:0] lit, output int acc);
      bit   ok = 0;
      logic illegal;
      bus.req_valid_in    = 1'b1;
      bus.req_we_in       = we;
      bus.req_size_in     = size;
      bus.req_unsigned_in = uns;
      bus.req_addr_in     = addr;
      bus.req_wdata_in    = wdata;
      acc = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bus.req_ready_out === 1'b1) begin
            ok = 1;
            break;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         check("accept_timeout", 32'd0, 32'd1);
         bus.req_valid_in = 1'b0;
         return;
      end
      acc = cyc;
      illegal = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
      if (model) begin
         if (illegal) begin
            rq.push_back('{acc + 1, 1'b1, 32'h0, use_lit, lit});
         end else if (we) begin
            logic [31:0] nw = model_store(addr, size, wdata);
            ref_mem[addr / 4] = nw;
            wq.push_back('{(size == 2'd2) ? acc : acc + 1, addr, nw, use_lit, lit});
            rq.push_back('{(size == 2'd2) ? acc + 1 : acc + 2, 1'b0, 32'h0, 1'b0, 32'h0});
         end else begin
            rq.push_back('{acc + 2, 1'b0, model_load(addr, size, uns), use_lit, lit});
         end
      end
      if (illegal) begin
         check("illegal_no_we", {31'd0, bus.mem_we_a_out}, 32'd0);
         check("illegal_no_en", {31'd0, bus.mem_en_b_out}, 32'd0);
      end else if (!(we && size == 2'd2)) begin
         check("read_en", {31'd0, bus.mem_en_b_out}, 32'd1);
         check("read_addr", {20'd0, bus.mem_addr_b_out}, {20'd0, addr});
      end
      @(posedge clk);
      #1;
      bus.req_valid_in = 1'b0;
   endtask

   // Per-cycle comparison of responses and SRAM writes against the model queues.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!rst) begin
            if (rq.size() > 0 && rq[0].due == cyc) begin
               check("resp_valid", {31'd0, bus.resp_valid_out}, 32'd1);
               check("resp_err", {31'd0, bus.resp_err_out}, {31'd0, rq[0].err});
               check("resp_rdata", bus.resp_rdata_out, rq[0].data);
               if (rq[0].use_lit) check("resp_literal", bus.resp_rdata_out, rq[0].lit);
               void'(rq.pop_front());
            end else begin
               check("resp_idle", {31'd0, bus.resp_valid_out}, 32'd0);
            end
            if (wq.size() > 0 && wq[0].due == cyc) begin
               check("write_we", {31'd0, bus.mem_we_a_out}, 32'd1);
               check("write_addr", {20'd0, bus.mem_addr_a_out}, {20'd0, wq[0].addr});
               check("write_data", bus.mem_din_a_out, wq[0].data);
               if (wq[0].use_lit) check("write_literal", bus.mem_din_a_out, wq[0].lit);
               void'(wq.pop_front());
            end else begin
               check("write_idle", {31'd0, bus.mem_we_a_out}, 32'd0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int a0, a1;
      bus.req_valid_in = 1'b0; bus.req_we_in = 1'b0; bus.req_size_in = 2'b00;
      bus.req_unsigned_in = 1'b0; bus.req_addr_in = 12'h0; bus.req_wdata_in = 32'h0;
      bus.mem_dout_b_in = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", {31'd0, bus.req_ready_out}, 32'd0);
      check("rst_valid", {31'd0, bus.resp_valid_out}, 32'd0);
      check("rst_rdata", bus.resp_rdata_out, 32'd0);
      check("rst_err", {31'd0, bus.resp_err_out}, 32'd0);
      check("rst_we", {31'd0, bus.mem_we_a_out}, 32'd0);
      check("rst_en", {31'd0, bus.mem_en_b_out}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      issue(1, 2'd2, 0, 12'h010, 32'h8899AABB, 1, 1, 32'h8899AABB, a0);
      issue(0, 2'd2, 0, 12'h010, 32'h0, 1, 1, 32'h8899AABB, a0);
      issue(0, 2'd0, 0, 12'h011, 32'h0, 1, 1, 32'hFFFFFFAA, a0);
      issue(0, 2'd0, 1, 12'h011, 32'h0, 1, 1, 32'h000000AA, a0);
      issue(0, 2'd1, 0, 12'h012, 32'h0, 1, 1, 32'hFFFF8899, a0);
      issue(0, 2'd1, 1, 12'h012, 32'h0, 1, 1, 32'h00008899, a0);
      issue(0, 2'd0, 0, 12'h010, 32'h0, 1, 1, 32'hFFFFFFBB, a0);
      issue(1, 2'd0, 0, 12'h013, 32'h12345677, 1, 1, 32'h7799AABB, a0);
      issue(0, 2'd2, 0, 12'h010, 32'h0, 1, 1, 32'h7799AABB, a0);

      issue(1, 2'd1, 0, 12'h011, 32'h0000CAFE, 1, 1, 32'h0, a0);
      issue(0, 2'd2, 0, 12'h012, 32'h0, 1, 1, 32'h0, a0);
      issue(0, 2'd3, 0, 12'h000, 32'h0, 1, 1, 32'h0, a0);

      // Reset lands on the merge cycle of a half-word store.
      issue(1, 2'd1, 0, 12'h010, 32'h0000CAFE, 0, 0, 32'h0, a0);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_we", {31'd0, bus.mem_we_a_out}, 32'd0);
      check("midrst_en", {31'd0, bus.mem_en_b_out}, 32'd0);
      check("midrst_ready", {31'd0, bus.req_ready_out}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("postrst_ready", {31'd0, bus.req_ready_out}, 32'd1);
      check("postrst_valid", {31'd0, bus.resp_valid_out}, 32'd0);
      check("postrst_rdata", bus.resp_rdata_out, 32'd0);
      check("postrst_we", {31'd0, bus.mem_we_a_out}, 32'd0);
      @(posedge clk);
      #1;
      issue(0, 2'd2, 0, 12'h010, 32'h0, 1, 1, 32'h7799AABB, a0);

      issue(1, 2'd2, 0, 12'h020, 32'h11223344, 1, 0, 32'h0, a0);
      issue(0, 2'd2, 0, 12'h020, 32'h0, 1, 1, 32'h11223344, a1);
      check("b2b_sw_lw", a1, a0 + 1);
      issue(0, 2'd0, 0, 12'h021, 32'h0, 1, 1, 32'h00000033, a0);
      issue(1, 2'd1, 0, 12'h022, 32'h0000BEEF, 1, 1, 32'hBEEF3344, a1);
      check("b2b_resp_accept", a1, a0 + 2);
      issue(0, 2'd2, 1, 12'h020, 32'h0, 1, 1, 32'hBEEF3344, a0);
      issue(0, 2'd1, 0, 12'h022, 32'h0, 1, 1, 32'hFFFFBEEF, a0);

      repeat (5) @(posedge clk);
      @(negedge clk);
      check("resp_queue_drained", rq.size(), 32'd0);
      check("write_queue_drained", wq.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
`default_nettype wire
